piece_driver: RTL and testbench
===============================

# piece_driver

Falling-piece controller for the Tetris playfield. It owns the active piece's reference position (`ref_x`, `ref_y`), applies gravity and player moves, and reacts to the `stop` and side-blocked flags returned by the collision/display mux. It issues `change_shape` at each spawn and `start_over` on restart. It sits between the synchronized key inputs and the collision/display mux, and is the only writer of piece position.

## Interface
Parameters:
- `BLOCK` — default 20 — cell size in pixels; every position step is one `BLOCK`.
- `FIELD_W` — default 480 — playfield width in pixels.
- `SPAWN_X` — default 280 — spawn x coordinate; `ref_y` at spawn is 0.
- `FALL_DIV` — default 12_500_000 — clocks per gravity tick (normal fall).
- `FAST_DIV` — default 1_250_000 — clocks per gravity tick while drop is held.
- `LOCK_CYC` — default 4 — clocks spent in LOCK so the collision block commits cells.

Ports:
- `iVGA_CLK` in 1 — sole clock.
- `iRST_N` in 1 — reset, asynchronous, active-low.
- `btn_left`, `btn_right`, `btn_drop`, `btn_start` in 1 each — synchronized active-high key levels.
- `stop` in 1 — piece cannot descend from its current position.
- `blk_left`, `blk_right` in 1 each — occupied cell adjacent on that side.
- `shape` in 3 — current shape code: 0 = square (width 2), 1 = horizontal bar (width 4), 2 = vertical bar (width 1); other codes are treated as width 1.
- `ref_x`, `ref_y` out 10 each — piece top-left pixel position.
- `change_shape` out 1 — one-cycle pulse on each spawn.
- `start_over` out 1 — one-cycle pulse on restart.
- `game_over` out 1 — level, high in state OVER.
- `piece_cnt` out 16 — number of locked pieces since the last restart.

## Operation
- Rising edges are detected on all `btn_*` inputs using registered previous values. Only edges act, except `btn_drop`, which acts as a level.
- FSM states: IDLE, SPAWN, FALL, LOCK, OVER.
- IDLE: entered at reset. A `btn_start` edge → `start_over` pulse → SPAWN.
- SPAWN (1 cycle): `ref_x` ← `SPAWN_X`, `ref_y` ← 0, `change_shape` pulses, tick divider cleared → FALL.
- FALL:
  - The divider counts to `FALL_DIV-1`, or to `FAST_DIV-1` while `btn_drop`=1. Terminal count produces a tick and the divider wraps to 0.
  - On a tick with `stop`=0: `ref_y` += `BLOCK`.
  - On a tick with `stop`=1 and `ref_y`≠0: go to LOCK.
  - On a tick with `stop`=1 and `ref_y`=0: go to OVER.
  - Left edge: applied when `blk_left`=0 and `ref_x` ≥ `BLOCK`; `ref_x` −= `BLOCK`.
  - Right edge: applied when `blk_right`=0 and `ref_x` + (w+1)·`BLOCK` ≤ `FIELD_W`, where w is the shape width; `ref_x` += `BLOCK`.
  - Left and right edges in the same cycle: neither is applied.
  - A lateral move and a gravity tick in the same cycle are both applied; the x and y updates are independent.
- LOCK: position is frozen; after `LOCK_CYC` clocks, `piece_cnt` +1 (wraps at 16 bits) → SPAWN.
- OVER: `game_over`=1 and position is frozen. A `btn_start` edge → `start_over` pulse, `piece_cnt` ← 0 → SPAWN.
- A `btn_start` edge in FALL or LOCK is ignored.
- Width rule: all position arithmetic is done in 11 bits, and the comparison uses the 11-bit sum. No wrap is allowed on `ref_x`.

## Timing
- Reset values: `ref_x`=`SPAWN_X`, `ref_y`=0, `change_shape`=0, `start_over`=0, `game_over`=0, `piece_cnt`=0, state IDLE, divider 0, edge registers 0.
- All outputs are registered. Position changes are visible the cycle after the tick or the edge.
- `stop`, `blk_*` and `shape` are sampled on the tick or edge cycle. They are combinational functions of the previous position, so there is one cycle of collision latency.
- `start_over` and the first `change_shape` are 1 cycle apart (restart cycle, then SPAWN cycle).
- Tick-to-move latency: 1 clock. Key edge-to-move latency: 2 clocks (edge register, then update).
- Reset asserted mid-FALL or mid-LOCK: immediate return to reset values; no lock is counted.

## Structure
- A shared `tetris_pkg` holds:
  - shape codes and the shape-width function;
  - the FSM state encoding;
  - `BLOCK` and `FIELD_W` defaults, so they are common with the collision/display mux.
- One natural sub-module: `tick_gen`, a programmable divider with clear, select (`FALL_DIV`/`FAST_DIV`) and a one-cycle tick output.
- Key edge detection stays inline.

## Test plan
Bench parameters: `FALL_DIV`=4, `FAST_DIV`=1, `LOCK_CYC`=2.
- Reset, then `btn_start` pulse → `start_over` 1 cycle, then `change_shape` 1 cycle, `ref_x`=280, `ref_y`=0. Every 4 clocks `ref_y` steps 20, 40, 60 while `stop`=0.
- Hold `btn_drop` → `ref_y` steps every clock. Release → back to every 4 clocks, with no skipped step.
- `shape`=1, `ref_x`=400, right edge → no move (400+100 > 480). `shape`=2 at `ref_x`=440 → moves to 460. `ref_x`=0, left edge → stays 0. `blk_left`=1 → left edge ignored.
- Assert `stop` at `ref_y`=200 → LOCK for 2 clocks, `piece_cnt` 0→1, respawn at (280, 0) with a `change_shape` pulse.
- `stop`=1 on the first tick after spawn → `game_over`=1 with position held. `btn_start` edge → `start_over` pulse, `piece_cnt`=0, then spawn.
- Drop `iRST_N` mid-FALL at `ref_y`=100 → all outputs return to reset values asynchronously; state is IDLE after release.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: shape codes, shape widths, FSM encoding and
// playfield geometry defaults common to the piece driver and collision mux.
package tetris_pkg;

  localparam int BLOCK_DEF   = 20;
  localparam int FIELD_W_DEF = 480;

  localparam logic [2:0] SHAPE_SQUARE = 3'd0;
  localparam logic [2:0] SHAPE_HBAR   = 3'd1;
  localparam logic [2:0] SHAPE_VBAR   = 3'd2;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SPAWN = 3'd1;
  localparam logic [2:0] ST_FALL  = 3'd2;
  localparam logic [2:0] ST_LOCK  = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  // Width in cells; unknown codes fall back to a single cell.
  function automatic logic [2:0] shape_width(input logic [2:0] shape);
    case (shape)
      SHAPE_SQUARE: return 3'd2;
      SHAPE_HBAR:   return 3'd4;
      SHAPE_VBAR:   return 3'd1;
      default:      return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Gravity divider: counts to FALL_DIV-1 (or FAST_DIV-1 when fast) and emits a
// one-cycle tick on terminal count; clr restarts the period.
module tick_gen #(
  parameter int FALL_DIV = 12_500_000,
  parameter int FAST_DIV = 1_250_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic fast,
  output logic tick
);

  localparam int CNT_W = (FALL_DIV > 1) ? $clog2(FALL_DIV) : 1;
  localparam logic [CNT_W-1:0] FALL_LIM = CNT_W'(FALL_DIV - 1);
  localparam logic [CNT_W-1:0] FAST_LIM = CNT_W'(FAST_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d, lim;
  logic             tick_hit;

  // >= rather than == so switching to the shorter period mid-count ticks at once.
  always_comb begin
    lim      = fast ? FAST_LIM : FALL_LIM;
    tick_hit = en && (cnt_q >= lim);
    cnt_d    = cnt_q;
    if (clr)           cnt_d = '0;
    else if (tick_hit) cnt_d = '0;
    else if (en)       cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = tick_hit;

endmodule

// File: rtl/piece_driver.sv
// Falling-piece controller: owns the active piece position, applies gravity
// and player moves, and sequences spawn, lock, game over and restart.
module piece_driver
  import tetris_pkg::*;
#(
  parameter int BLOCK    = BLOCK_DEF,
  parameter int FIELD_W  = FIELD_W_DEF,
  parameter int SPAWN_X  = 280,
  parameter int FALL_DIV = 12_500_000,
  parameter int FAST_DIV = 1_250_000,
  parameter int LOCK_CYC = 4
) (
  input  logic        iVGA_CLK,
  input  logic        iRST_N,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_drop,
  input  logic        btn_start,
  input  logic        stop,
  input  logic        blk_left,
  input  logic        blk_right,
  input  logic [2:0]  shape,
  output logic [9:0]  ref_x,
  output logic [9:0]  ref_y,
  output logic        change_shape,
  output logic        start_over,
  output logic        game_over,
  output logic [15:0] piece_cnt
);

  localparam int LK_W = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
  localparam logic [LK_W-1:0] LOCK_LAST = LK_W'(LOCK_CYC - 1);
  localparam logic [10:0] BLOCK_W   = 11'(BLOCK);
  localparam logic [10:0] FIELD_W_W = 11'(FIELD_W);
  localparam logic [9:0]  SPAWN_X_W = 10'(SPAWN_X);

  logic [2:0]      state_q, state_d;
  logic [9:0]      ref_x_q, ref_x_d, ref_y_q, ref_y_d;
  logic            change_shape_q, change_shape_d;
  logic            start_over_q, start_over_d;
  logic            game_over_q, game_over_d;
  logic [15:0]     piece_cnt_q, piece_cnt_d;
  logic [LK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic            btn_left_q, btn_right_q, btn_start_q;
  logic            left_edge_q, left_edge_d;
  logic            right_edge_q, right_edge_d;
  logic            start_edge_q, start_edge_d;

  logic        tick, tick_clr, tick_en;
  logic [10:0] x_ext, y_ext, w_plus1, right_reach;
  logic        mv_left, mv_right;

  tick_gen #(
    .FALL_DIV(FALL_DIV),
    .FAST_DIV(FAST_DIV)
  ) u_tick (
    .clk  (iVGA_CLK),
    .rst_n(iRST_N),
    .clr  (tick_clr),
    .en   (tick_en),
    .fast (btn_drop),
    .tick (tick)
  );

  // Edges are registered so moves land two clocks after the key rises.
  always_comb begin
    left_edge_d  = btn_left  & ~btn_left_q;
    right_edge_d = btn_right & ~btn_right_q;
    start_edge_d = btn_start & ~btn_start_q;
  end

  // Lateral legality in 11 bits so the right-edge sum cannot wrap.
  always_comb begin
    x_ext       = {1'b0, ref_x_q};
    y_ext       = {1'b0, ref_y_q};
    w_plus1     = {8'd0, shape_width(shape)} + 11'd1;
    right_reach = x_ext + w_plus1 * BLOCK_W;
    mv_left     = left_edge_q && !right_edge_q && !blk_left && (x_ext >= BLOCK_W);
    mv_right    = right_edge_q && !left_edge_q && !blk_right && (right_reach <= FIELD_W_W);
  end

  always_comb begin
    state_d        = state_q;
    ref_x_d        = ref_x_q;
    ref_y_d        = ref_y_q;
    change_shape_d = 1'b0;
    start_over_d   = 1'b0;
    piece_cnt_d    = piece_cnt_q;
    lock_cnt_d     = '0;
    tick_clr       = 1'b0;
    tick_en        = (state_q == ST_FALL);
    case (state_q)
      ST_IDLE: begin
        if (start_edge_q) begin
          start_over_d = 1'b1;
          state_d      = ST_SPAWN;
        end
      end
      ST_SPAWN: begin
        ref_x_d        = SPAWN_X_W;
        ref_y_d        = '0;
        change_shape_d = 1'b1;
        tick_clr       = 1'b1;
        state_d        = ST_FALL;
      end
      ST_FALL: begin
        if (mv_left)       ref_x_d = 10'(x_ext - BLOCK_W);
        else if (mv_right) ref_x_d = 10'(x_ext + BLOCK_W);
        if (tick) begin
          if (!stop)                ref_y_d = 10'(y_ext + BLOCK_W);
          else if (ref_y_q != '0)   state_d = ST_LOCK;
          else                      state_d = ST_OVER;
        end
      end
      ST_LOCK: begin
        if (lock_cnt_q == LOCK_LAST) begin
          piece_cnt_d = piece_cnt_q + 16'd1;
          state_d     = ST_SPAWN;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      ST_OVER: begin
        if (start_edge_q) begin
          start_over_d = 1'b1;
          piece_cnt_d  = '0;
          state_d      = ST_SPAWN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    game_over_d = (state_d == ST_OVER);
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q        <= ST_IDLE;
      ref_x_q        <= SPAWN_X_W;
      ref_y_q        <= '0;
      change_shape_q <= 1'b0;
      start_over_q   <= 1'b0;
      game_over_q    <= 1'b0;
      piece_cnt_q    <= '0;
      lock_cnt_q     <= '0;
      btn_left_q     <= 1'b0;
      btn_right_q    <= 1'b0;
      btn_start_q    <= 1'b0;
      left_edge_q    <= 1'b0;
      right_edge_q   <= 1'b0;
      start_edge_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      ref_x_q        <= ref_x_d;
      ref_y_q        <= ref_y_d;
      change_shape_q <= change_shape_d;
      start_over_q   <= start_over_d;
      game_over_q    <= game_over_d;
      piece_cnt_q    <= piece_cnt_d;
      lock_cnt_q     <= lock_cnt_d;
      btn_left_q     <= btn_left;
      btn_right_q    <= btn_right;
      btn_start_q    <= btn_start;
      left_edge_q    <= left_edge_d;
      right_edge_q   <= right_edge_d;
      start_edge_q   <= start_edge_d;
    end
  end

  assign ref_x        = ref_x_q;
  assign ref_y        = ref_y_q;
  assign change_shape = change_shape_q;
  assign start_over   = start_over_q;
  assign game_over    = game_over_q;
  assign piece_cnt    = piece_cnt_q;

endmodule

// File: tb/tb_piece_driver.sv
// Directed bench for piece_driver with short divider periods so gravity,
// lateral moves, lock, game over, restart and reset can be walked by hand.
module tb_piece_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_left, btn_right, btn_drop, btn_start;
  logic        stop, blk_left, blk_right;
  logic [2:0]  shape;
  logic [9:0]  ref_x, ref_y;
  logic        change_shape, start_over, game_over;
  logic [15:0] piece_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  piece_driver #(
    .FALL_DIV(4),
    .FAST_DIV(1),
    .LOCK_CYC(2)
  ) dut (
    .iVGA_CLK    (clk),
    .iRST_N      (rst_n),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_drop    (btn_drop),
    .btn_start   (btn_start),
    .stop        (stop),
    .blk_left    (blk_left),
    .blk_right   (blk_right),
    .shape       (shape),
    .ref_x       (ref_x),
    .ref_y       (ref_y),
    .change_shape(change_shape),
    .start_over  (start_over),
    .game_over   (game_over),
    .piece_cnt   (piece_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-clock key press followed by release; the move is visible on return.
  task automatic press(input logic l, input logic r);
    btn_left  = l;
    btn_right = r;
    clk_n(1);
    btn_left  = 1'b0;
    btn_right = 1'b0;
    clk_n(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    rst_n = 1'b0;
    btn_left = 0; btn_right = 0; btn_drop = 0; btn_start = 0;
    stop = 0; blk_left = 0; blk_right = 0; shape = 3'd0;

    clk_n(3);
    chk("rst_ref_x", ref_x, 280);
    chk("rst_ref_y", ref_y, 0);
    chk("rst_change_shape", change_shape, 0);
    chk("rst_start_over", start_over, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_piece_cnt", piece_cnt, 0);
    rst_n = 1'b1;
    clk_n(2);
    chk("idle_no_fall", ref_y, 0);

    // Start: edge register, then start_over, then spawn
    btn_start = 1'b1;
    clk_n(1);
    btn_start = 1'b0;
    chk("start_edge_reg", start_over, 0);
    clk_n(1);
    chk("start_over_pulse", start_over, 1);
    chk("no_spawn_yet", change_shape, 0);
    clk_n(1);
    chk("start_over_end", start_over, 0);
    chk("spawn_pulse", change_shape, 1);
    chk("spawn_x", ref_x, 280);
    chk("spawn_y", ref_y, 0);

    // Normal gravity every 4 clocks
    clk_n(3);
    chk("spawn_pulse_end", change_shape, 0);
    chk("pre_tick1_y", ref_y, 0);
    clk_n(1);
    chk("tick1_y", ref_y, 20);
    clk_n(3);
    chk("pre_tick2_y", ref_y, 20);
    clk_n(1);
    chk("tick2_y", ref_y, 40);
    clk_n(4);
    chk("tick3_y", ref_y, 60);

    // Fast drop every clock, then back to 4 clocks without skipping
    btn_drop = 1'b1;
    clk_n(1);
    chk("drop1_y", ref_y, 80);
    clk_n(1);
    chk("drop2_y", ref_y, 100);
    clk_n(1);
    chk("drop3_y", ref_y, 120);
    btn_drop = 1'b0;
    clk_n(3);
    chk("release_hold_y", ref_y, 120);
    clk_n(1);
    chk("release_tick_y", ref_y, 140);
    clk_n(12);
    chk("reach_200", ref_y, 200);

    // Lock at 200
    stop = 1'b1;
    clk_n(3);
    chk("stop_wait_y", ref_y, 200);
    clk_n(1);
    chk("lock_y_held", ref_y, 200);
    chk("lock_cnt_before", piece_cnt, 0);
    stop = 1'b0;
    clk_n(1);
    chk("lock_cyc1_cnt", piece_cnt, 0);
    chk("lock_no_spawn", change_shape, 0);
    clk_n(1);
    chk("lock_counted", piece_cnt, 1);
    clk_n(1);
    chk("respawn_pulse", change_shape, 1);
    chk("respawn_x", ref_x, 280);
    chk("respawn_y", ref_y, 0);

    // Start edge in FALL is ignored
    btn_start = 1'b1;
    clk_n(1);
    btn_start = 1'b0;
    clk_n(1);
    chk("start_in_fall", start_over, 0);

    // Lateral moves
    blk_left = 1'b1;
    press(1, 0);
    chk("blk_left_ignored", ref_x, 280);
    blk_left = 1'b0;
    blk_right = 1'b1;
    press(0, 1);
    chk("blk_right_ignored", ref_x, 280);
    blk_right = 1'b0;
    press(1, 1);
    chk("both_edges", ref_x, 280);
    press(0, 1);
    chk("right_300", ref_x, 300);
    repeat (5) press(0, 1);
    chk("right_400", ref_x, 400);
    shape = 3'd1;
    press(0, 1);
    chk("hbar_wall", ref_x, 400);
    shape = 3'd2;
    press(0, 1);
    press(0, 1);
    chk("vbar_440", ref_x, 440);
    press(0, 1);
    chk("vbar_460", ref_x, 460);
    press(0, 1);
    chk("vbar_wall", ref_x, 460);
    repeat (23) press(1, 0);
    chk("left_to_0", ref_x, 0);
    press(1, 0);
    chk("left_wall", ref_x, 0);

    // Lock this piece, then stop on the first tick after spawn -> game over
    shape = 3'd0;
    stop = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      clk_n(1);
      if (change_shape) found = 1'b1;
    end
    chk("respawn2_seen", found, 1);
    chk("respawn2_cnt", piece_cnt, 2);
    chk("respawn2_x", ref_x, 280);
    clk_n(3);
    chk("pre_over", game_over, 0);
    clk_n(1);
    chk("game_over_set", game_over, 1);
    chk("over_y_held", ref_y, 0);
    press(1, 0);
    chk("over_x_frozen", ref_x, 280);
    chk("over_level", game_over, 1);
    stop = 1'b0;

    // Restart from OVER
    btn_start = 1'b1;
    clk_n(1);
    btn_start = 1'b0;
    chk("restart_edge_reg", start_over, 0);
    clk_n(1);
    chk("restart_pulse", start_over, 1);
    chk("restart_cnt_clr", piece_cnt, 0);
    chk("restart_over_clr", game_over, 0);
    clk_n(1);
    chk("restart_spawn", change_shape, 1);
    chk("restart_y", ref_y, 0);

    // Reset mid-FALL at y=100
    btn_drop = 1'b1;
    clk_n(5);
    chk("fall_to_100", ref_y, 100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_y", ref_y, 0);
    chk("async_rst_x", ref_x, 280);
    chk("async_rst_over", game_over, 0);
    btn_drop = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clk_n(6);
    chk("post_rst_idle_y", ref_y, 0);
    chk("post_rst_no_pulse", start_over, 0);
    btn_start = 1'b1;
    clk_n(1);
    btn_start = 1'b0;
    clk_n(1);
    chk("post_rst_start", start_over, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
